// File: rtl/uart_config_requester_pkg.sv
// Package: uart_config_requester_pkg
// Shared UART configuration-protocol types and constants: the configuration
// struct, packet IDs, SYN/ACK byte values, the requester FSM encoding and
// the packet assembly helper used by the configuration requester.
package uart_config_requester_pkg;

    // Synchronisation byte that opens every configuration sequence
    localparam logic [7:0] SYN = 8'h16;

    // Number of SYN bytes sent before the first configuration packet
    localparam int unsigned SYN_NUMBER = 3;

    // The device echoes SYN once it has applied the configuration
    localparam logic [7:0] CFG_ACK = SYN;

    // Packet identifiers carried in the low two bits of each packet
    localparam logic [1:0] END_CONFIGURATION_ID = 2'd0;
    localparam logic [1:0] DATA_WIDTH_ID        = 2'd1;
    localparam logic [1:0] PARITY_MODE_ID       = 2'd2;
    localparam logic [1:0] STOP_BITS_ID         = 2'd3;

    typedef enum logic [1:0] {
        DW_5BIT = 2'd0,
        DW_6BIT = 2'd1,
        DW_7BIT = 2'd2,
        DW_8BIT = 2'd3
    } data_width_e;

    typedef enum logic [1:0] {
        EVEN      = 2'd0,
        ODD       = 2'd1,
        DISABLED1 = 2'd2,
        DISABLED2 = 2'd3
    } parity_mode_e;

    typedef enum logic [1:0] {
        SB_1BIT   = 2'd0,
        SB_2BIT   = 2'd1,
        RESERVED1 = 2'd2,
        RESERVED2 = 2'd3
    } stop_bits_e;

    typedef struct packed {
        data_width_e  data_width;
        parity_mode_e parity_mode;
        stop_bits_e   stop_bits;
    } uart_config_s;

    // Requester FSM encoding, also the type of the debug state output
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYN      = 3'd1,
        ST_DW       = 3'd2,
        ST_PM       = 3'd3,
        ST_SB       = 3'd4,
        ST_END      = 3'd5,
        ST_WAIT_ACK = 3'd6
    } cfg_req_fsm_e;

    // Packet layout: {4'b0000, value[1:0], id[1:0]}
    function automatic logic [7:0] assemble_packet(input logic [1:0] id,
                                                   input logic [1:0] value);
        return {4'b0000, value, id};
    endfunction

    // Stop-bit codes the device cannot honour
    function automatic logic stop_bits_illegal(input stop_bits_e sb);
        return (sb == RESERVED1) || (sb == RESERVED2);
    endfunction

endpackage

// File: rtl/uart_config_requester_if.sv
// Interface: uart_config_requester_if
// Groups the host request/status signals, the TX FIFO write handshake and
// the snooped RX FIFO read side of the configuration requester.
//
// Handshake: tx_valid_o/tx_ready_i follow strict valid/ready rules. Once
// tx_valid_o is high, tx_data_o stays constant and tx_valid_o stays high
// until the cycle where tx_ready_i is also high; that cycle is the transfer.
// tx_ready_i while tx_valid_o is low has no effect. rx_valid_i is a
// one-cycle strobe with no back-pressure.
interface uart_config_requester_if;
    import uart_config_requester_pkg::*;

    logic         start_i;
    uart_config_s cfg_i;
    logic [7:0]   tx_data_o;
    logic         tx_valid_o;
    logic         tx_ready_i;
    logic [7:0]   rx_data_i;
    logic         rx_valid_i;
    logic         busy_o;
    logic         done_o;
    logic         error_o;

    // Host / bench side
    modport master (
        output start_i, cfg_i, tx_ready_i, rx_data_i, rx_valid_i,
        input  tx_data_o, tx_valid_o, busy_o, done_o, error_o
    );

    // Requester side
    modport slave (
        input  start_i, cfg_i, tx_ready_i, rx_data_i, rx_valid_i,
        output tx_data_o, tx_valid_o, busy_o, done_o, error_o
    );

endinterface

// File: rtl/uart_config_requester.sv
// Module: uart_config_requester
// Host-side initiator of the UART configuration protocol. On an accepted
// start it streams SYN x SYN_NUMBER, the data-width, parity and stop-bit
// packets and the END packet to the TX path, one byte per transfer.
// Optional feature macro: CFG_ACK_CHECK_EN -- when defined, the requester
// waits after END for the remote acknowledge, with an ACK_TIMEOUT-cycle
// timeout. When undefined, the RX inputs are unused.
module uart_config_requester
    import uart_config_requester_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1_000_000
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    uart_config_requester_if.slave        bus,
    output cfg_req_fsm_e                  state_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYN  = 3'd1;
    localparam logic [2:0] S_DW   = 3'd2;
    localparam logic [2:0] S_PM   = 3'd3;
    localparam logic [2:0] S_SB   = 3'd4;
    localparam logic [2:0] S_END  = 3'd5;

    localparam logic [1:0] SYN_LAST = 2'(SYN_NUMBER - 1);

    logic [2:0]   state_q,   state_d;
    logic [1:0]   syn_cnt_q, syn_cnt_d;
    uart_config_s cfg_q,     cfg_d;
    logic         done_q,    done_d;
    logic         error_q,   error_d;

    logic         tx_valid;
    logic [7:0]   tx_data;
    logic         tx_fire;

`ifdef CFG_ACK_CHECK_EN
    localparam logic [2:0] S_WAIT_ACK = 3'd6;
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] ack_cnt_q, ack_cnt_d;
`else
    // RX side and timeout are not part of this build
    logic unused_rx;
    assign unused_rx = ^{bus.rx_data_i, bus.rx_valid_i, ACK_TIMEOUT[0], CFG_ACK};
`endif

    // Byte presented to the TX path; a pure function of the registered
    // state, so it is stable for as long as the transfer is stalled
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            S_SYN: begin
                tx_valid = 1'b1;
                tx_data  = SYN;
            end
            S_DW: begin
                tx_valid = 1'b1;
                tx_data  = assemble_packet(DATA_WIDTH_ID, cfg_q.data_width);
            end
            S_PM: begin
                tx_valid = 1'b1;
                tx_data  = assemble_packet(PARITY_MODE_ID, cfg_q.parity_mode);
            end
            S_SB: begin
                tx_valid = 1'b1;
                tx_data  = assemble_packet(STOP_BITS_ID, cfg_q.stop_bits);
            end
            S_END: begin
                tx_valid = 1'b1;
                tx_data  = assemble_packet(END_CONFIGURATION_ID, 2'b00);
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    assign tx_fire = tx_valid & bus.tx_ready_i;

    // Sequencer: start acceptance, per-byte advance and completion status
    always_comb begin
        state_d   = state_q;
        syn_cnt_d = syn_cnt_q;
        cfg_d     = cfg_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
`ifdef CFG_ACK_CHECK_EN
        ack_cnt_d = ack_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (stop_bits_illegal(bus.cfg_i.stop_bits)) begin
                        error_d = 1'b1;
                    end else begin
                        cfg_d     = bus.cfg_i;
                        syn_cnt_d = 2'd0;
                        state_d   = S_SYN;
                    end
                end
            end
            S_SYN: begin
                if (tx_fire) begin
                    if (syn_cnt_q == SYN_LAST) begin
                        syn_cnt_d = 2'd0;
                        state_d   = S_DW;
                    end else begin
                        syn_cnt_d = syn_cnt_q + 2'd1;
                    end
                end
            end
            S_DW: begin
                if (tx_fire) begin
                    state_d = S_PM;
                end
            end
            S_PM: begin
                if (tx_fire) begin
                    state_d = S_SB;
                end
            end
            S_SB: begin
                if (tx_fire) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                if (tx_fire) begin
`ifdef CFG_ACK_CHECK_EN
                    state_d   = S_WAIT_ACK;
                    ack_cnt_d = '0;
`else
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
`endif
                end
            end
`ifdef CFG_ACK_CHECK_EN
            S_WAIT_ACK: begin
                // A received byte takes priority over the final timeout count
                if (bus.rx_valid_i) begin
                    state_d = S_IDLE;
                    if (bus.rx_data_i == CFG_ACK) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, latched configuration and status pulses
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            syn_cnt_q <= 2'd0;
            cfg_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            syn_cnt_q <= syn_cnt_d;
            cfg_q     <= cfg_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

`ifdef CFG_ACK_CHECK_EN
    // Acknowledge timeout counter, cleared when END is accepted
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_cnt_q <= '0;
        end else begin
            ack_cnt_q <= ack_cnt_d;
        end
    end
`endif

    assign bus.tx_valid_o = tx_valid;
    assign bus.tx_data_o  = tx_data;
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.done_o     = done_q;
    assign bus.error_o    = error_q;
    assign state_o        = cfg_req_fsm_e'(state_q);

endmodule
